// File: rtl/fetch_stage.sv
// Fetch stage: owns PCF, issues in-order instruction memory requests,
// buffers returned words and drives the F/D pipeline register.
module fetch_stage #(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic        ImemReqValid,
    output logic [31:0] ImemReqAddr,
    input  logic        ImemReqReady,
    input  logic        ImemRspValid,
    input  logic [31:0] ImemRspData,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        InstrValidD
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST  = PW'(FIFO_DEPTH - 1);

    logic [31:0]   buf_word [FIFO_DEPTH];
    logic [31:0]   buf_pc   [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [31:0]   rsp_pc;

    logic        redirect;
    logic        issue_ok;
    logic        accept;
    logic        rsp_drop;
    logic        rsp_keep;
    logic        take;
    logic        bypass;
    logic        push;
    logic        pop;
    logic [31:0] head_word;
    logic [31:0] head_pc;

    assign redirect     = PCSrcW | BranchTakenE;
    assign issue_ok     = ({1'b0, inflight} + {1'b0, count}) < DEPTH;
    assign ImemReqValid = !reset && !redirect && !StallF && issue_ok;
    assign ImemReqAddr  = PCF;
    assign accept       = ImemReqValid && ImemReqReady;

    assign rsp_drop = ImemRspValid && (drop != '0);
    assign rsp_keep = ImemRspValid && (drop == '0) && !redirect;

    // A kept response may skip the empty buffer and go straight to decode
    assign take   = !redirect && !FlushD && !StallD
                  && ((count != '0) || rsp_keep);
    assign bypass = take && (count == '0);
    assign push   = rsp_keep && !bypass;
    assign pop    = take && (count != '0);

    assign head_word = bypass ? ImemRspData : buf_word[rd_ptr];
    assign head_pc   = bypass ? rsp_pc      : buf_pc[rd_ptr];

    // rsp_pc tracks the PC of the next response that will be kept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PCF    <= RESET_PC;
            rsp_pc <= RESET_PC;
        end else if (PCSrcW) begin
            PCF    <= ResultW;
            rsp_pc <= ResultW;
        end else if (BranchTakenE) begin
            PCF    <= BranchTargetE;
            rsp_pc <= BranchTargetE;
        end else begin
            if (accept)
                PCF <= PCF + 32'd4;
            if (rsp_keep)
                rsp_pc <= rsp_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + CW'(accept) - CW'(ImemRspValid);
            if (redirect)
                drop <= inflight - CW'(ImemRspValid);
            else if (rsp_drop)
                drop <= drop - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_word[wr_ptr] <= ImemRspData;
            buf_pc[wr_ptr]   <= rsp_pc;
        end
        if (!reset) begin
            assert (!(push && !pop && count == FULL));
            assert (!(ImemRspValid && inflight == '0));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InstrD      <= NOP_INSTR;
            PCPlus8D    <= '0;
            InstrValidD <= 1'b0;
        end else if (redirect || FlushD) begin
            InstrD      <= NOP_INSTR;
            InstrValidD <= 1'b0;
        end else if (!StallD) begin
            if (take) begin
                InstrD      <= head_word;
                PCPlus8D    <= head_pc + 32'd8;
                InstrValidD <= 1'b1;
            end else begin
                InstrD      <= NOP_INSTR;
                InstrValidD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with a variable-latency memory model
// that returns each word equal to its address.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        BranchTakenE = 1'b0;
    logic [31:0] BranchTargetE = '0;
    logic        PCSrcW = 1'b0;
    logic [31:0] ResultW = '0;
    logic        ImemReqValid;
    logic [31:0] ImemReqAddr;
    logic        ImemReqReady = 1'b1;
    logic        ImemRspValid = 1'b0;
    logic [31:0] ImemRspData = '0;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCPlus8D;
    logic        InstrValidD;

    fetch_stage dut (
        .clk(clk),
        .reset(reset),
        .StallF(StallF),
        .StallD(StallD),
        .FlushD(FlushD),
        .BranchTakenE(BranchTakenE),
        .BranchTargetE(BranchTargetE),
        .PCSrcW(PCSrcW),
        .ResultW(ResultW),
        .ImemReqValid(ImemReqValid),
        .ImemReqAddr(ImemReqAddr),
        .ImemReqReady(ImemReqReady),
        .ImemRspValid(ImemRspValid),
        .ImemRspData(ImemRspData),
        .PCF(PCF),
        .InstrD(InstrD),
        .PCPlus8D(PCPlus8D),
        .InstrValidD(InstrValidD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc8;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    exp_t sb[$];
    req_t pend[$];
    exp_t mon_e;
    req_t mem_r;
    int   total = 0;
    int   bad = 0;
    int   lat = 1;
    int   cyc = 0;
    int   found;
    logic stall_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] pc);
        sb.push_back('{pc, pc + 32'd8});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Memory: capture the handshake that completes at the coming edge
    always @(negedge clk) begin
        if (!reset && ImemReqValid && ImemReqReady)
            pend.push_back('{ImemReqAddr, cyc + lat});
    end

    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (reset) begin
            pend.delete();
            ImemRspValid = 1'b0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_r = pend.pop_front();
            ImemRspValid = 1'b1;
            ImemRspData = mem_r.addr;
        end else begin
            ImemRspValid = 1'b0;
        end
    end

    // A valid F/D word after an unstalled edge is a newly loaded one
    always @(posedge clk) stall_q <= StallD;

    always @(negedge clk) begin
        if (!reset && InstrValidD && !stall_q) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_instr: got %h want none", InstrD);
            end else begin
                mon_e = sb.pop_front();
                check("instr", InstrD, mon_e.instr);
                check("pc8", PCPlus8D, mon_e.pc8);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pcf", PCF, 32'h0);
        check("rst_instr", InstrD, NOP);
        check("rst_pc8", PCPlus8D, 32'h0);
        check("rst_valid", 32'(InstrValidD), 32'd0);
        check("rst_req", 32'(ImemReqValid), 32'd0);
        tick();
        reset = 1'b0;

        // Streaming at one word per cycle
        for (int i = 0; i < 8; i++) expect_word(32'(4 * i));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t1_addr", ImemReqAddr, 32'(4 * i));
            check("t1_req", 32'(ImemReqValid), 32'd1);
            if (i < 2) check("t1_bubble", 32'(InstrValidD), 32'd0);
            tick();
        end
        StallF = 1'b1;
        ticks(4);
        @(negedge clk);
        check("t1_pcf", PCF, 32'h20);
        check("t1_noreq", 32'(ImemReqValid), 32'd0);
        check("t1_drain", 32'(sb.size()), 32'd0);

        // Branch with two slow requests in flight
        tick();
        lat = 3;
        StallF = 1'b0;
        tick();
        tick();
        BranchTakenE = 1'b1;
        BranchTargetE = 32'h100;
        expect_word(32'h100);
        @(negedge clk);
        check("t2_redir_req", 32'(ImemReqValid), 32'd0);
        tick();
        BranchTakenE = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (ImemReqValid) found = 1;
        end
        check("t2_found", 32'(found), 32'd1);
        check("t2_addr", ImemReqAddr, 32'h100);
        tick();
        StallF = 1'b1;
        ticks(10);
        @(negedge clk);
        check("t2_pcf", PCF, 32'h104);
        check("t2_drain", 32'(sb.size()), 32'd0);

        // StallD while the buffer fills
        tick();
        lat = 1;
        StallD = 1'b1;
        StallF = 1'b0;
        expect_word(32'h104);
        expect_word(32'h108);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i >= 2) check("t3_noissue", 32'(ImemReqValid), 32'd0);
            if (i == 3) check("t3_held", 32'(InstrValidD), 32'd0);
            tick();
        end
        StallD = 1'b0;
        StallF = 1'b1;
        ticks(5);
        @(negedge clk);
        check("t3_pcf", PCF, 32'h10C);
        check("t3_drain", 32'(sb.size()), 32'd0);

        // PCSrcW and BranchTakenE together, buffered word flushed
        tick();
        StallF = 1'b0;
        expect_word(32'h10C);
        tick();
        tick();
        StallF = 1'b1;
        StallD = 1'b1;
        tick();
        PCSrcW = 1'b1;
        ResultW = 32'h200;
        BranchTakenE = 1'b1;
        BranchTargetE = 32'h300;
        @(negedge clk);
        check("t4_pre_valid", 32'(InstrValidD), 32'd1);
        check("t4_pre_instr", InstrD, 32'h10C);
        check("t4_redir_req", 32'(ImemReqValid), 32'd0);
        tick();
        PCSrcW = 1'b0;
        BranchTakenE = 1'b0;
        StallD = 1'b0;
        @(negedge clk);
        check("t4_pcf", PCF, 32'h200);
        check("t4_bubble", 32'(InstrValidD), 32'd0);
        check("t4_nop", InstrD, NOP);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_empty", 32'(InstrValidD), 32'd0);
        end
        check("t4_drain", 32'(sb.size()), 32'd0);

        // Memory not ready for three cycles
        tick();
        ImemReqReady = 1'b0;
        StallF = 1'b0;
        expect_word(32'h200);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_valid", 32'(ImemReqValid), 32'd1);
            check("t5_addr", ImemReqAddr, 32'h200);
            check("t5_pcf", PCF, 32'h200);
            tick();
        end
        ImemReqReady = 1'b1;
        @(negedge clk);
        check("t5_addr_hs", ImemReqAddr, 32'h200);
        tick();
        StallF = 1'b1;
        @(negedge clk);
        check("t5_pcf_adv", PCF, 32'h204);
        ticks(4);
        @(negedge clk);
        check("t5_drain", 32'(sb.size()), 32'd0);

        // Asynchronous reset with two requests in flight
        tick();
        lat = 3;
        StallF = 1'b0;
        tick();
        @(negedge clk);
        check("t6_pre_pcf", PCF, 32'h208);
        check("t6_pre_pc8", PCPlus8D, 32'h208);
        tick();
        StallF = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("t6_pcf", PCF, 32'h0);
        check("t6_instr", InstrD, NOP);
        check("t6_pc8", PCPlus8D, 32'h0);
        check("t6_valid", 32'(InstrValidD), 32'd0);
        check("t6_req", 32'(ImemReqValid), 32'd0);
        tick();
        reset = 1'b0;
        lat = 1;
        StallF = 1'b0;
        expect_word(32'h0);
        expect_word(32'h4);
        @(negedge clk);
        check("t6_restart", ImemReqAddr, 32'h0);
        tick();
        tick();
        StallF = 1'b1;
        ticks(5);
        @(negedge clk);
        check("t6_drain", 32'(sb.size()), 32'd0);

        // Wrap-around of PCF and PC+8
        tick();
        BranchTakenE = 1'b1;
        BranchTargetE = 32'hFFFF_FFFC;
        expect_word(32'hFFFF_FFFC);
        expect_word(32'h0);
        tick();
        BranchTakenE = 1'b0;
        StallF = 1'b0;
        tick();
        tick();
        StallF = 1'b1;
        @(negedge clk);
        check("t7_pcf", PCF, 32'h4);
        ticks(4);
        @(negedge clk);
        check("t7_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
